ping_pong_rd_ctrl: RTL and testbench
====================================

# ping_pong_rd_ctrl

Read-side controller for the two-bank ping-pong input buffer feeding the systolic matmul array. It waits for the write-side controller to declare a bank full, then replays that bank's even/odd row pair through ports A/B for `N_PASSES` column passes, paced by the array's per-block `step`. When the last pass finishes, it hands the bank back with a one-cycle release pulse. Banks are consumed in strict alternation, starting with bank 0.

## Interface
- `ADDR_WIDTH`, default 4: BRAM address width; must satisfy 2^ADDR_WIDTH >= 2*COL_X.
- `COL_X`, default 4: blocks per row. Port A reads 0..COL_X-1 (even row); port B reads COL_X..2*COL_X-1 (odd row).
- `N_PASSES`, default 2: full re-reads of a bank before release (one per output column).
- `RD_LATENCY`, default 2: BRAM read latency in cycles, ≥1.
---
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `bank_full`  in  2  level from the writer; bit b is high while bank b holds unread data.
- `step`  in  1  array accepted the current block; advance to the next.
- `bank_release`  out  2  one-cycle pulse; bit b means bank b may be refilled.
- `bank0_en`, `bank1_en`  out  1 each  read enable (both ports) of that bank.
- `bank0_addra`, `bank0_addrb`, `bank1_addra`, `bank1_addrb`  out  ADDR_WIDTH each  read addresses.
- `rd_valid`  out  1  BRAM output data for an issued address is valid this cycle.
- `rd_bank`  out  1  data mux select, aligned with `rd_valid`.
- `rd_blk`  out  clog2(COL_X) (min 1)  block index, aligned with `rd_valid`.
- `rd_pass`  out  clog2(N_PASSES) (min 1)  pass index, aligned with `rd_valid`.
- `bank_done`  out  1  one-cycle pulse, coincident with `bank_release`.

## Operation
- State register `cur` (1 bit, reset 0), block counter `blk`, pass counter `pass`.
- FSM states: IDLE, READ, RELEASE.
  - IDLE: if `bank_full[cur]`, go to READ. Load `blk`=0 and `pass`=0. Issue address 0.
  - READ, `step` high, not at the end: `blk`+1. On `blk`==COL_X-1, wrap `blk` to 0 and increment `pass`. Each advance issues a new address.
  - READ, `step` high, `blk`==COL_X-1 and `pass`==N_PASSES-1: go to RELEASE. No new issue.
  - RELEASE: pulse `bank_release[cur]` and `bank_done`, toggle `cur`, go to IDLE.
- Addresses: `addra`=blk, `addrb`=COL_X+blk, zero-extended to ADDR_WIDTH. Only bank `cur` is updated; the other bank's address outputs hold their value.
- `bankN_en` is high only while in READ with `cur`==N.
- `step` is ignored in IDLE and RELEASE.
- `bank_full[~cur]` is ignored until that bank becomes `cur`.
- A drop of `bank_full[cur]` during READ is ignored; this is a writer protocol violation.
- Reset mid-operation: return to IDLE, `cur`=0, counters 0, valid pipeline flushed. No release pulse is emitted.
- Reset values: all outputs 0, including all addresses, `bank_release`, `rd_valid`, and the tags.

## Timing
- An address issued on clock edge E is visible on the outputs in the cycle after E.
- `rd_valid` is high for exactly one cycle, RD_LATENCY cycles after the address becomes visible. `rd_bank`/`rd_blk`/`rd_pass` are delayed identically through a RD_LATENCY-deep shift pipeline.
- Back-to-back `step` gives one issue per cycle and a fully pipelined `rd_valid` stream.
- Minimum bank occupancy: 1 (IDLE→READ) + COL_X*N_PASSES steps + 1 (RELEASE) + 1 (IDLE).
- `bank_release` is registered and rises in the cycle after the final `step` edge.

## Configuration
- `PP_RD_PREFETCH_EN`
  - Defined: in RELEASE, if `bank_full[~cur]` is high, go directly to READ on the new bank. This loads `blk`=`pass`=0 and issues address 0 in the same edge, removing the IDLE cycle between banks.
  - Undefined: RELEASE always goes to IDLE.

## Test plan
- Reset, then `bank_full`=2'b01 with `step` held high (COL_X=4, N_PASSES=2) -> `bank0_addra` reads 0,1,2,3,0,1,2,3 and `addrb` reads 4..7 twice. 8 `rd_valid` pulses, each 2 cycles after its address. `bank_release`=2'b01 one cycle after the 8th step.
- `bank_full`=2'b10 only after reset -> no enable and no `rd_valid`; `cur` stays 0 until bank 0 fills.
- Both banks full, continuous `step` -> bank 0 is drained, then bank 1, with `rd_bank` 0 then 1. Without the macro there is exactly one IDLE cycle between them (enable low for 2 cycles). With `PP_RD_PREFETCH_EN`, the gap is 1 cycle.
- `step` toggling every other cycle -> addresses advance only on `step`. `rd_valid` pulses are spaced 2 cycles apart; tags are correct.
- Reset asserted after the 5th step -> all outputs 0 the next cycle. No `bank_release` pulse. Pending `rd_valid` pulses are suppressed.
- Boundary: `blk`==3 and `pass`==0 with `step` -> `blk`=0 and `pass`=1, `addra`=0, `addrb`=4. No release.

Source files
------------

// File: rtl/ping_pong_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ping_pong_rd_ctrl
//  Description : Read-side controller for a two-bank ping-pong input buffer
//                feeding a systolic matmul array. It waits until the current
//                bank is declared full. It then replays the bank's even row
//                (port A) and odd row (port B) N_PASSES times, advancing one
//                block per accepted step. When done, it returns the bank to
//                the writer with a one-cycle release pulse. Banks alternate
//                strictly, starting with bank 0.
//  Macro       : PP_RD_PREFETCH_EN - when defined, RELEASE goes straight to
//                READ on the other bank if that bank is already full.
//  Ports       : clk, rst_n (sync, active-low)
//                i_bank_full[1:0]   writer's per-bank "holds data" level
//                i_step             array accepted the current block
//                o_bank_release[1:0] one-cycle "bank may be refilled" pulse
//                o_bank{0,1}_en     read enable of each bank (both ports)
//                o_bank{0,1}_addr{a,b} read addresses
//                o_rd_valid/o_rd_bank/o_rd_blk/o_rd_pass  data-aligned tags
//                o_bank_done        pulse coincident with o_bank_release
//  Revision    : 1.0 - initial release
// ============================================================================
module ping_pong_rd_ctrl #(
    parameter  int ADDR_WIDTH = 4,
    parameter  int COL_X      = 4,
    parameter  int N_PASSES   = 2,
    parameter  int RD_LATENCY = 2,
    localparam int C_BLK_W    = (COL_X > 1)    ? $clog2(COL_X)    : 1,
    localparam int C_PASS_W   = (N_PASSES > 1) ? $clog2(N_PASSES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            i_bank_full,
    input  logic                  i_step,
    output logic [1:0]            o_bank_release,
    output logic                  o_bank0_en,
    output logic                  o_bank1_en,
    output logic [ADDR_WIDTH-1:0] o_bank0_addra,
    output logic [ADDR_WIDTH-1:0] o_bank0_addrb,
    output logic [ADDR_WIDTH-1:0] o_bank1_addra,
    output logic [ADDR_WIDTH-1:0] o_bank1_addrb,
    output logic                  o_rd_valid,
    output logic                  o_rd_bank,
    output logic [C_BLK_W-1:0]    o_rd_blk,
    output logic [C_PASS_W-1:0]   o_rd_pass,
    output logic                  o_bank_done
);

    localparam logic [C_BLK_W-1:0]    c_BLK_LAST  = C_BLK_W'(COL_X - 1);
    localparam logic [C_PASS_W-1:0]   c_PASS_LAST = C_PASS_W'(N_PASSES - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ODD_BASE  = ADDR_WIDTH'(COL_X);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_cur;
    logic [C_BLK_W-1:0]    r_blk;
    logic [C_PASS_W-1:0]   r_pass;
    logic [1:0]            r_en;
    logic [ADDR_WIDTH-1:0] r_addra [2];
    logic [ADDR_WIDTH-1:0] r_addrb [2];
    logic [1:0]            r_release;
    logic                  r_done;

    // Issue stage: tags of the address that became visible this cycle.
    logic                  r_iss_v;
    logic                  r_iss_bank;
    logic [C_BLK_W-1:0]    r_iss_blk;
    logic [C_PASS_W-1:0]   r_iss_pass;

    // RD_LATENCY-deep shift pipeline tracking BRAM read latency.
    logic [RD_LATENCY-1:0] r_pv;
    logic [RD_LATENCY-1:0] r_pbank;
    logic [C_BLK_W-1:0]    r_pblk  [RD_LATENCY];
    logic [C_PASS_W-1:0]   r_ppass [RD_LATENCY];

    logic                  w_wrap;
    logic                  w_last;
    logic                  w_issue;
    logic                  w_iss_bank;
    logic [C_BLK_W-1:0]    w_iss_blk;
    logic [C_PASS_W-1:0]   w_iss_pass;
    logic [ADDR_WIDTH-1:0] w_addra;
    logic [ADDR_WIDTH-1:0] w_addrb;

    // Decide whether this edge issues a new address, and for which block.
    always_comb begin
        w_wrap     = (r_blk == c_BLK_LAST);
        w_last     = w_wrap && (r_pass == c_PASS_LAST);
        w_issue    = 1'b0;
        w_iss_bank = r_cur;
        w_iss_blk  = '0;
        w_iss_pass = '0;
        case (r_state)
            S_IDLE: begin
                w_issue = i_bank_full[r_cur];
            end
            S_READ: begin
                if (i_step && !w_last) begin
                    w_issue = 1'b1;
                    if (w_wrap) begin
                        w_iss_blk  = '0;
                        w_iss_pass = r_pass + 1'b1;
                    end else begin
                        w_iss_blk  = r_blk + 1'b1;
                        w_iss_pass = r_pass;
                    end
                end
            end
            S_RELEASE: begin
`ifdef PP_RD_PREFETCH_EN
                // The next bank is already full: start it on the same edge
                // that hands the current one back.
                w_issue    = i_bank_full[~r_cur];
                w_iss_bank = ~r_cur;
`endif
            end
            default: begin
                w_issue = 1'b0;
            end
        endcase
        w_addra = ADDR_WIDTH'(w_iss_blk);
        w_addrb = c_ODD_BASE + ADDR_WIDTH'(w_iss_blk);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cur      <= 1'b0;
            r_blk      <= '0;
            r_pass     <= '0;
            r_en       <= '0;
            r_addra[0] <= '0;
            r_addra[1] <= '0;
            r_addrb[0] <= '0;
            r_addrb[1] <= '0;
            r_release  <= '0;
            r_done     <= 1'b0;
            r_iss_v    <= 1'b0;
            r_iss_bank <= 1'b0;
            r_iss_blk  <= '0;
            r_iss_pass <= '0;
            r_pv       <= '0;
            r_pbank    <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pblk[i]  <= '0;
                r_ppass[i] <= '0;
            end
        end else begin
            r_release <= '0;
            r_done    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_bank_full[r_cur]) begin
                        r_state     <= S_READ;
                        r_en[r_cur] <= 1'b1;
                    end
                end
                S_READ: begin
                    if (i_step && w_last) begin
                        r_state          <= S_RELEASE;
                        r_en             <= '0;
                        r_release[r_cur] <= 1'b1;
                        r_done           <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    r_cur   <= ~r_cur;
                    r_state <= S_IDLE;
`ifdef PP_RD_PREFETCH_EN
                    if (i_bank_full[~r_cur]) begin
                        r_state      <= S_READ;
                        r_en[~r_cur] <= 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Only the bank being issued to updates its addresses; the
            // other bank's outputs hold.
            if (w_issue) begin
                r_blk               <= w_iss_blk;
                r_pass              <= w_iss_pass;
                r_addra[w_iss_bank] <= w_addra;
                r_addrb[w_iss_bank] <= w_addrb;
            end
            r_iss_v    <= w_issue;
            r_iss_bank <= w_iss_bank;
            r_iss_blk  <= w_iss_blk;
            r_iss_pass <= w_iss_pass;

            r_pv[0]     <= r_iss_v;
            r_pbank[0]  <= r_iss_bank;
            r_pblk[0]   <= r_iss_blk;
            r_ppass[0]  <= r_iss_pass;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i]    <= r_pv[i-1];
                r_pbank[i] <= r_pbank[i-1];
                r_pblk[i]  <= r_pblk[i-1];
                r_ppass[i] <= r_ppass[i-1];
            end
        end
    end

    assign o_bank_release = r_release;
    assign o_bank_done    = r_done;
    assign o_bank0_en     = r_en[0];
    assign o_bank1_en     = r_en[1];
    assign o_bank0_addra  = r_addra[0];
    assign o_bank0_addrb  = r_addrb[0];
    assign o_bank1_addra  = r_addra[1];
    assign o_bank1_addrb  = r_addrb[1];
    assign o_rd_valid     = r_pv[RD_LATENCY-1];
    assign o_rd_bank      = r_pbank[RD_LATENCY-1];
    assign o_rd_blk       = r_pblk[RD_LATENCY-1];
    assign o_rd_pass      = r_ppass[RD_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_ping_pong_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ping_pong_rd_ctrl
//  Description : Directed self-checking bench for ping_pong_rd_ctrl with
//                default parameters (ADDR_WIDTH=4, COL_X=4, N_PASSES=2,
//                RD_LATENCY=2). Inputs change and outputs are sampled on the
//                falling edge; cycle c means "just after rising edge c".
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ping_pong_rd_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] bank_full;
    logic       step;
    logic [1:0] bank_release;
    logic       bank0_en;
    logic       bank1_en;
    logic [3:0] bank0_addra;
    logic [3:0] bank0_addrb;
    logic [3:0] bank1_addra;
    logic [3:0] bank1_addrb;
    logic       rd_valid;
    logic       rd_bank;
    logic [1:0] rd_blk;
    logic [0:0] rd_pass;
    logic       bank_done;

    int checks;
    int errors;

    ping_pong_rd_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_bank_full    (bank_full),
        .i_step         (step),
        .o_bank_release (bank_release),
        .o_bank0_en     (bank0_en),
        .o_bank1_en     (bank1_en),
        .o_bank0_addra  (bank0_addra),
        .o_bank0_addrb  (bank0_addrb),
        .o_bank1_addra  (bank1_addra),
        .o_bank1_addrb  (bank1_addrb),
        .o_rd_valid     (rd_valid),
        .o_rd_bank      (rd_bank),
        .o_rd_blk       (rd_blk),
        .o_rd_pass      (rd_pass),
        .o_bank_done    (bank_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        bank_full = 2'b00;
        step      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // status = {en0, en1, rd_valid, bank_release[1:0], bank_done}
    task automatic test_reset();
        logic [25:0] all_out;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            all_out = {bank_release, bank0_en, bank1_en, bank0_addra, bank0_addrb,
                       bank1_addra, bank1_addrb, rd_valid, rd_bank, rd_blk, rd_pass, bank_done};
            checks++;
            if (all_out !== 26'd0) begin
                errors++;
                $display("FAIL reset_outputs c=%0d got %h exp 0", c, all_out);
            end
            tick();
        end
    endtask

    task automatic test_single_bank();
        logic [5:0] e_st;
        logic [3:0] e_a;
        int         i;
        do_reset();
        bank_full = 2'b01;
        step      = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            if (c == 10) bank_full = 2'b00;
            tick();
            e_st = {(c <= 8), 1'b0, (c >= 3 && c <= 10), (c == 9) ? 2'b01 : 2'b00, (c == 9)};
            checks++;
            if ({bank0_en, bank1_en, rd_valid, bank_release, bank_done} !== e_st) begin
                errors++;
                $display("FAIL single_status c=%0d got %b exp %b", c,
                         {bank0_en, bank1_en, rd_valid, bank_release, bank_done}, e_st);
            end
            e_a = (c <= 8) ? 4'((c - 1) % 4) : 4'd3;
            checks++;
            if (bank0_addra !== e_a || bank0_addrb !== (e_a + 4'd4) ||
                bank1_addra !== 4'd0 || bank1_addrb !== 4'd0) begin
                errors++;
                $display("FAIL single_addr c=%0d got a=%0d b=%0d b1=%0d/%0d exp a=%0d b=%0d b1=0/0",
                         c, bank0_addra, bank0_addrb, bank1_addra, bank1_addrb, e_a, e_a + 4'd4);
            end
            if (c >= 3 && c <= 10) begin
                i = c - 3;
                checks++;
                if (rd_bank !== 1'b0 || rd_blk !== 2'(i % 4) || rd_pass !== 1'(i / 4)) begin
                    errors++;
                    $display("FAIL single_tags c=%0d got bank=%0d blk=%0d pass=%0d exp 0/%0d/%0d",
                             c, rd_bank, rd_blk, rd_pass, i % 4, i / 4);
                end
            end
            // blk wraps 3 -> 0 and pass 0 -> 1 without a release
            if (c == 5) begin
                checks++;
                if (bank0_addra !== 4'd0 || bank0_addrb !== 4'd4 || bank_release !== 2'b00) begin
                    errors++;
                    $display("FAIL wrap_boundary got a=%0d b=%0d rel=%b exp a=0 b=4 rel=00",
                             bank0_addra, bank0_addrb, bank_release);
                end
            end
        end
    endtask

    task automatic test_wrong_bank();
        do_reset();
        bank_full = 2'b10;
        step      = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if ({bank0_en, bank1_en, rd_valid, bank_release, bank_done} !== 6'd0) begin
                errors++;
                $display("FAIL wrong_bank_idle c=%0d got %b exp 000000", c,
                         {bank0_en, bank1_en, rd_valid, bank_release, bank_done});
            end
        end
        bank_full = 2'b11;
        tick();
        checks++;
        if (bank0_en !== 1'b1 || bank1_en !== 1'b0) begin
            errors++;
            $display("FAIL wrong_bank_cur got en0=%b en1=%b exp en0=1 en1=0", bank0_en, bank1_en);
        end
    endtask

    task automatic test_back_to_back();
        int         b1;
        logic [5:0] e_st;
        logic [3:0] e_a0;
        logic [3:0] e_a1;
        logic [3:0] e_b1;
        logic       e_v;
        logic       e_bank;
        int         i;
`ifdef PP_RD_PREFETCH_EN
        b1 = 10;
`else
        b1 = 11;
`endif
        do_reset();
        bank_full = 2'b11;
        step      = 1'b1;
        for (int c = 1; c <= b1 + 10; c++) begin
            if (c == 10) bank_full = 2'b10;
            if (c == b1 + 9) bank_full = 2'b00;
            tick();
            e_v  = (c >= 3 && c <= 10) || (c >= b1 + 2 && c <= b1 + 9);
            e_st = {(c <= 8), (c >= b1 && c <= b1 + 7), e_v,
                    (c == 9) ? 2'b01 : ((c == b1 + 8) ? 2'b10 : 2'b00),
                    (c == 9) || (c == b1 + 8)};
            checks++;
            if ({bank0_en, bank1_en, rd_valid, bank_release, bank_done} !== e_st) begin
                errors++;
                $display("FAIL b2b_status c=%0d got %b exp %b", c,
                         {bank0_en, bank1_en, rd_valid, bank_release, bank_done}, e_st);
            end
            e_a0 = (c <= 8) ? 4'((c - 1) % 4) : 4'd3;
            e_a1 = (c < b1) ? 4'd0 : ((c <= b1 + 7) ? 4'((c - b1) % 4) : 4'd3);
            e_b1 = (c < b1) ? 4'd0 : e_a1 + 4'd4;
            checks++;
            if (bank0_addra !== e_a0 || bank0_addrb !== (e_a0 + 4'd4) ||
                bank1_addra !== e_a1 || bank1_addrb !== e_b1) begin
                errors++;
                $display("FAIL b2b_addr c=%0d got %0d/%0d %0d/%0d exp %0d/%0d %0d/%0d", c,
                         bank0_addra, bank0_addrb, bank1_addra, bank1_addrb,
                         e_a0, e_a0 + 4'd4, e_a1, e_b1);
            end
            if (e_v) begin
                e_bank = (c >= b1 + 2);
                i      = e_bank ? (c - b1 - 2) : (c - 3);
                checks++;
                if (rd_bank !== e_bank || rd_blk !== 2'(i % 4) || rd_pass !== 1'(i / 4)) begin
                    errors++;
                    $display("FAIL b2b_tags c=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", c,
                             rd_bank, rd_blk, rd_pass, e_bank, i % 4, i / 4);
                end
            end
        end
    endtask

    task automatic test_step_toggle();
        logic [5:0] e_st;
        logic [3:0] e_a;
        int         i;
        do_reset();
        bank_full = 2'b01;
        for (int c = 1; c <= 18; c++) begin
            step = (c % 2 == 1);
            if (c == 18) bank_full = 2'b00;
            tick();
            e_st = {(c <= 16), 1'b0, (c >= 3 && c <= 17 && c % 2 == 1),
                    (c == 17) ? 2'b01 : 2'b00, (c == 17)};
            checks++;
            if ({bank0_en, bank1_en, rd_valid, bank_release, bank_done} !== e_st) begin
                errors++;
                $display("FAIL toggle_status c=%0d got %b exp %b", c,
                         {bank0_en, bank1_en, rd_valid, bank_release, bank_done}, e_st);
            end
            e_a = (c <= 16) ? 4'(((c - 1) / 2) % 4) : 4'd3;
            checks++;
            if (bank0_addra !== e_a || bank0_addrb !== (e_a + 4'd4)) begin
                errors++;
                $display("FAIL toggle_addr c=%0d got %0d/%0d exp %0d/%0d", c,
                         bank0_addra, bank0_addrb, e_a, e_a + 4'd4);
            end
            if (c >= 3 && c <= 17 && c % 2 == 1) begin
                i = (c - 3) / 2;
                checks++;
                if (rd_bank !== 1'b0 || rd_blk !== 2'(i % 4) || rd_pass !== 1'(i / 4)) begin
                    errors++;
                    $display("FAIL toggle_tags c=%0d got %0d/%0d/%0d exp 0/%0d/%0d", c,
                             rd_bank, rd_blk, rd_pass, i % 4, i / 4);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [25:0] all_out;
        do_reset();
        bank_full = 2'b01;
        step      = 1'b1;
        // edge 1 enters READ, edges 2..6 are the first five steps
        for (int c = 1; c <= 6; c++) tick();
        checks++;
        if (bank0_addra !== 4'd1 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre got a=%0d v=%b exp a=1 v=1", bank0_addra, rd_valid);
        end
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        bank_full = 2'b00;
        for (int c = 7; c <= 10; c++) begin
            all_out = {bank_release, bank0_en, bank1_en, bank0_addra, bank0_addrb,
                       bank1_addra, bank1_addrb, rd_valid, rd_bank, rd_blk, rd_pass, bank_done};
            checks++;
            if (all_out !== 26'd0) begin
                errors++;
                $display("FAIL midrst_zero c=%0d got %h exp 0", c, all_out);
            end
            tick();
        end
        bank_full = 2'b01;
        tick();
        checks++;
        if (bank0_en !== 1'b1 || bank1_en !== 1'b0 || bank0_addra !== 4'd0) begin
            errors++;
            $display("FAIL midrst_restart got en0=%b en1=%b a=%0d exp 1/0/0",
                     bank0_en, bank1_en, bank0_addra);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bank_full = 2'b00;
        step      = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_bank();
        test_wrong_bank();
        test_back_to_back();
        test_step_toggle();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
